multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle sequencer for the RV32I core: steps FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
//  Sources the 3-bit ImmSel for the immediate generator from the opcode held in the instruction register.
//  Owns the single shared memory port for fetch and load/store, and routes illegal opcodes and memory timeouts to a trap.
// PARAMETERS
//  TIMEOUT_CYCLES  255  memory-wait limit per request; 0 disables the timeout
//  CNT_W           8    width of the wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk         in   1   core clock
//  rst         in   1   asynchronous, active-high reset
//  ir          in   32  instruction register contents, valid from DECODE onward
//  mem_ready   in   1   memory completes the current request this cycle
//  br_taken    in   1   branch comparison result, valid in EXEC
//  ir_we       out  1   load ir from memory read data
//  pc_we       out  1   update PC
//  pc_sel      out  2   0 pc+4, 1 pc+imm, 2 alu result (JALR), 3 trap vector
//  mem_req     out  1   memory request
//  mem_we      out  1   store request
//  mem_fetch   out  1   request is an instruction fetch
//  reg_we      out  1   register file write
//  wb_sel      out  2   0 alu, 1 mem, 2 pc+4
//  alu_a_pc    out  1   ALU A operand = PC (AUIPC)
//  alu_b_imm   out  1   ALU B operand = imm_out
//  imm_sel     out  3   0 I, 1 S, 2 B, 3 JAL, 4 LUI/AUIPC, 5 JALR
//  trap        out  1   one-cycle trap pulse
//  state       out  3   FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
// BEHAVIOUR
//  Registered: state, imm_sel, wait counter. All other outputs decode combinationally from state, opcode, mem_ready, br_taken.
//  While rst is high: state=FETCH, imm_sel=0, counter=0, every strobe and trap forced to 0.
//  FETCH: mem_req=1, mem_fetch=1. On mem_ready: ir_we=1, go to DECODE.
//  DECODE: classify ir[6:0] and register imm_sel. LOAD/OP-IMM/OP=0 (OP is don't-care, drive 0), STORE=1, BRANCH=2, JAL=3, LUI/AUIPC=4, JALR=5.
//   Unknown opcode, or ir[1:0]!=2'b11, goes to TRAP with imm_sel unchanged. Otherwise go to EXEC.
//  EXEC: alu_b_imm=1 for all formats except OP and BRANCH; alu_a_pc=1 for AUIPC.
//   BRANCH: pc_we=1, pc_sel=br_taken?1:0, go to FETCH.
//   JAL: reg_we=1, wb_sel=2, pc_we=1, pc_sel=1, go to FETCH.
//   JALR: same as JAL but pc_sel=2.
//   LOAD/STORE go to MEM; all others go to WB.
//  MEM: mem_req=1, mem_we=STORE. On mem_ready: STORE sets pc_we=1, pc_sel=0 and goes to FETCH; LOAD goes to WB.
//  WB: reg_we=1, wb_sel=LOAD?1:0, pc_we=1, pc_sel=0, go to FETCH.
//  TRAP: trap=1, pc_we=1, pc_sel=3, go to FETCH. Exactly one cycle.
//  Wait counter:
//   - Cleared on entry to FETCH or MEM.
//   - Increments each cycle mem_req=1 and mem_ready=0.
//   - If count==TIMEOUT_CYCLES-1 with no ready (TIMEOUT_CYCLES>0), next state is TRAP. mem_ready in that same cycle wins over the timeout.
//  mem_ready is ignored outside FETCH and MEM. mem_req stays high until ready or timeout.
//  Reset mid-operation aborts the access; mem_req drops in the same cycle (asynchronous).
//  Unused state codes 6 and 7 recover to FETCH on the next clock.
// CONFIGURATION
//  MULTICYCLE_CTRL_PERF_EN defined: adds outputs cycle_cnt[31:0] and retired_cnt[31:0], both reset to 0.
//   - cycle_cnt increments every clock out of reset.
//   - retired_cnt increments on every transition into FETCH except from TRAP.
//   - Both wrap modulo 2^32.
//  MULTICYCLE_CTRL_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  Reset: assert rst mid-MEM -> state=0, all strobes 0 immediately. Release rst -> mem_req=1, mem_fetch=1 in the first cycle.
//  ADDI 0x00500093, ready on 2nd FETCH cycle -> DECODE, EXEC, WB; imm_sel=0; WB: reg_we=1, wb_sel=0, pc_sel=0.
//  SW 0x00112223, ready 3 cycles late in MEM -> imm_sel=1; mem_req=1, mem_we=1 held 4 cycles; then pc_we=1 and return to FETCH.
//  BEQ 0x00000463 -> imm_sel=2. br_taken=1: pc_sel=1. br_taken=0: pc_sel=0. Both return to FETCH from EXEC.
//  JAL 0x008000EF -> imm_sel=3, reg_we=1, wb_sel=2, pc_sel=1. JALR 0x000080E7 -> imm_sel=5, pc_sel=2.
//  Faults: ir=0x00000000 -> TRAP, trap=1 for 1 cycle, pc_sel=3. With TIMEOUT_CYCLES=4 and no mem_ready -> TRAP after 4 request cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with a shared memory port.
// Define MULTICYCLE_CTRL_PERF_EN to add the cycle_cnt / retired_cnt performance counters.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_fetch,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_pc,
  output logic        alu_b_imm,
  output logic [2:0]  imm_sel,
  output logic        trap,
  output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  // state  | meaning
  // FETCH  | instruction read on the shared memory port
  // DECODE | classify opcode, register imm_sel
  // EXEC   | ALU step; branches and jumps finish here
  // MEM    | load/store access
  // WB     | register write-back and PC+4
  // TRAP   | one-cycle trap pulse, PC <- trap vector
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam bit             TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic [6:0]       opc;
  logic             is_load, is_opimm, is_op, is_store, is_branch;
  logic             is_jal, is_jalr, is_lui, is_auipc, legal;
  logic [2:0]       imm_dec;
  logic             timed_out;
  logic             ir_unused;

  assign opc       = ir[6:0];
  assign ir_unused = ^ir[31:7];
  assign is_load   = (opc == OPC_LOAD);
  assign is_opimm  = (opc == OPC_OPIMM);
  assign is_op     = (opc == OPC_OP);
  assign is_store  = (opc == OPC_STORE);
  assign is_branch = (opc == OPC_BRANCH);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_lui    = (opc == OPC_LUI);
  assign is_auipc  = (opc == OPC_AUIPC);
  assign legal     = is_load | is_opimm | is_op | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  always_comb begin
    imm_dec = 3'd0;
    if (is_store)              imm_dec = 3'd1;
    else if (is_branch)        imm_dec = 3'd2;
    else if (is_jal)           imm_dec = 3'd3;
    else if (is_lui | is_auipc) imm_dec = 3'd4;
    else if (is_jalr)          imm_dec = 3'd5;
  end

  // Only meaningful while a request is outstanding; a same-cycle ready beats the timeout.
  assign timed_out = TO_EN && (wait_cnt == CNT_LAST) && !mem_ready;
  assign state     = state_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= FETCH;
      imm_sel  <= 3'd0;
      wait_cnt <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == DECODE && legal) imm_sel <= imm_dec;
      if (state_n != state_r && (state_n == FETCH || state_n == MEM)) wait_cnt <= '0;
      else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state_r;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_fetch = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    trap      = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req   = 1'b1;
        mem_fetch = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_n = DECODE;
        end else if (timed_out) begin
          state_n = TRAP;
        end
      end
      DECODE: state_n = legal ? EXEC : TRAP;
      EXEC: begin
        alu_b_imm = !(is_op || is_branch);
        alu_a_pc  = is_auipc;
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? 2'd1 : 2'd0;
          state_n = FETCH;
        end else if (is_jal || is_jalr) begin
          reg_we  = 1'b1;
          wb_sel  = 2'd2;
          pc_we   = 1'b1;
          pc_sel  = is_jalr ? 2'd2 : 2'd1;
          state_n = FETCH;
        end else if (is_load || is_store) begin
          state_n = MEM;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_n = FETCH;
          end else begin
            state_n = WB;
          end
        end else if (timed_out) begin
          state_n = TRAP;
        end
      end
      WB: begin
        reg_we  = 1'b1;
        wb_sel  = is_load ? 2'd1 : 2'd0;
        pc_we   = 1'b1;
        state_n = FETCH;
      end
      TRAP: begin
        trap    = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = 2'd3;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    // Reset kills every strobe immediately, including an in-flight memory request.
    if (rst) begin
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_fetch = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 2'd0;
      alu_a_pc  = 1'b0;
      alu_b_imm = 1'b0;
      trap      = 1'b0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state_n == FETCH && state_r != FETCH && state_r != TRAP)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations from a behavioural model, checked at each PC update.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = 32'd0;
  logic        mem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        ir_we, pc_we, mem_req, mem_we, mem_fetch, reg_we, alu_a_pc, alu_b_imm, trap;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  multicycle_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready), .br_taken(br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .mem_req(mem_req), .mem_we(mem_we),
    .mem_fetch(mem_fetch), .reg_we(reg_we), .wb_sel(wb_sel), .alu_a_pc(alu_a_pc),
    .alu_b_imm(alu_b_imm), .imm_sel(imm_sel), .trap(trap), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    int          cycles;
    logic        trap;
    logic [1:0]  pc_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [2:0]  imm;
    int          we_cycles;
    int          irwe;
    logic        bimm;
    logic        apc;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0, done_cnt = 0;
  int         f_lat = 0, m_lat = 0;
  bit         mon_en = 0;
  logic [2:0] model_imm = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-instruction outcome from the ISA-level rules: latencies in, cycle count and end strobes out.
  function automatic exp_t model(input logic [31:0] instr, input int f, input int m, input logic br);
    exp_t e;
    logic [6:0] op;
    int fc;
    bit ok;
    e = '{default: 0};
    e.ir = instr;
    op = instr[6:0];
    if (f >= T) begin
      e.cycles = T + 1; e.trap = 1; e.pc_sel = 2'd3; e.imm = model_imm;
      return e;
    end
    fc = f + 1;
    e.irwe = 1;
    ok = 1;
    case (op)
      7'h03, 7'h13, 7'h33: e.imm = 3'd0;
      7'h23:               e.imm = 3'd1;
      7'h63:               e.imm = 3'd2;
      7'h6F:               e.imm = 3'd3;
      7'h37, 7'h17:        e.imm = 3'd4;
      7'h67:               e.imm = 3'd5;
      default:             ok = 0;
    endcase
    if (!ok) begin
      e.cycles = fc + 2; e.trap = 1; e.pc_sel = 2'd3; e.imm = model_imm;
      return e;
    end
    model_imm = e.imm;
    e.bimm = !(op == 7'h33 || op == 7'h63);
    e.apc  = (op == 7'h17);
    if (op == 7'h63) begin
      e.cycles = fc + 2; e.pc_sel = br ? 2'd1 : 2'd0;
    end else if (op == 7'h6F || op == 7'h67) begin
      e.cycles = fc + 2; e.reg_we = 1; e.wb_sel = 2'd2; e.pc_sel = (op == 7'h67) ? 2'd2 : 2'd1;
    end else if (op == 7'h03 || op == 7'h23) begin
      if (m >= T) begin
        e.cycles = fc + 2 + T + 1; e.trap = 1; e.pc_sel = 2'd3; e.we_cycles = (op == 7'h23) ? T : 0;
      end else if (op == 7'h23) begin
        e.cycles = fc + 2 + m + 1; e.we_cycles = m + 1;
      end else begin
        e.cycles = fc + 2 + m + 2; e.reg_we = 1; e.wb_sel = 2'd1;
      end
    end else begin
      e.cycles = fc + 3; e.reg_we = 1;
    end
    return e;
  endfunction

  // Memory responder: answers each request after f_lat / m_lat wait cycles.
  bit rsp_done = 1;
  int wc = 0;
  always @(negedge clk) rsp_done = !mem_req || mem_ready;
  always @(posedge clk) begin
    #3;
    if (rsp_done) wc = 0;
    else wc++;
    mem_ready = mem_req && (wc == (mem_fetch ? f_lat : m_lat));
  end

  // Monitor: accumulates per-instruction activity, compares when the PC is updated.
  int cyc = 0, we_c = 0, irwe_c = 0;
  bit bimm_o = 0, apc_o = 0;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      cyc = 0; we_c = 0; irwe_c = 0; bimm_o = 0; apc_o = 0;
    end else begin
      cyc++;
      if (mem_we) we_c++;
      if (ir_we) irwe_c++;
      bimm_o |= alu_b_imm;
      apc_o  |= alu_a_pc;
      if (pc_we) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("cycles[%h]", e.ir), cyc, e.cycles);
          chk($sformatf("trap[%h]", e.ir), 32'(trap), 32'(e.trap));
          chk($sformatf("pc_sel[%h]", e.ir), 32'(pc_sel), 32'(e.pc_sel));
          chk($sformatf("reg_we[%h]", e.ir), 32'(reg_we), 32'(e.reg_we));
          chk($sformatf("wb_sel[%h]", e.ir), 32'(wb_sel), 32'(e.wb_sel));
          chk($sformatf("imm_sel[%h]", e.ir), 32'(imm_sel), 32'(e.imm));
          chk($sformatf("store_cycles[%h]", e.ir), we_c, e.we_cycles);
          chk($sformatf("ir_we_count[%h]", e.ir), irwe_c, e.irwe);
          chk($sformatf("alu_b_imm[%h]", e.ir), 32'(bimm_o), 32'(e.bimm));
          chk($sformatf("alu_a_pc[%h]", e.ir), 32'(apc_o), 32'(e.apc));
        end
        cyc = 0; we_c = 0; irwe_c = 0; bimm_o = 0; apc_o = 0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic [31:0] instr, input int f, input int m, input logic br);
    int target;
    sb.push_back(model(instr, f, m, br));
    ir = instr; f_lat = f; m_lat = m; br_taken = br;
    target = done_cnt + 1;
    for (int i = 0; i < 40 && done_cnt < target; i++) @(posedge clk);
    chk("done_wait", done_cnt, target);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_fetch"}, 32'(mem_fetch), 32'd0);
    chk({tag, "_pc_we"}, 32'(pc_we), 32'd0);
    chk({tag, "_reg_we"}, 32'(reg_we), 32'd0);
    chk({tag, "_trap"}, 32'(trap), 32'd0);
    chk({tag, "_imm_sel"}, 32'(imm_sel), 32'd0);
  endtask

  logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  initial begin
    repeat (3) @(posedge clk);
    #2 chk_idle("rst");
    @(posedge clk); #1;
    f_lat = 1;
    mon_en = 1;
    rst = 1'b0;
    #1;
    chk("rel_mem_req", 32'(mem_req), 32'd1);
    chk("rel_mem_fetch", 32'(mem_fetch), 32'd1);

    issue(32'h00500093, 1, 0, 1'b0);   // ADDI
    issue(32'h00112223, 0, 3, 1'b0);   // SW, ready on the last allowed cycle
    issue(32'h00000463, 0, 0, 1'b1);   // BEQ taken
    issue(32'h00000463, 2, 0, 1'b0);   // BEQ not taken
    issue(32'h008000EF, 0, 0, 1'b0);   // JAL
    issue(32'h000080E7, 3, 0, 1'b0);   // JALR
    issue(32'h00000000, 0, 0, 1'b0);   // illegal
    issue(32'h00500093, 99, 0, 1'b0);  // fetch timeout
    issue(32'h0000A103, 0, 99, 1'b0);  // LW timeout
    issue(32'h00112223, 1, 4, 1'b0);   // SW timeout
    issue(32'h000012B7, 0, 0, 1'b0);   // LUI
    issue(32'h00001297, 0, 0, 1'b0);   // AUIPC
    issue(32'h002081B3, 0, 0, 1'b0);   // ADD
    issue(32'h0000A103, 3, 0, 1'b0);   // LW

    for (int k = 0; k < 80; k++) begin
      logic [31:0] instr;
      instr = $urandom;
      if ($urandom_range(3) == 0) instr[6:0] = 7'($urandom);
      else instr[6:0] = ops[$urandom_range(8)];
      issue(instr, $urandom_range(4), $urandom_range(4), 1'($urandom_range(1)));
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    mon_en = 0;
    ir = 32'h0000A103; f_lat = 0; m_lat = 99;
    for (int i = 0; i < 20 && state != 3'd3; i++) begin
      @(posedge clk); #1;
    end
    chk("reach_mem", 32'(state), 32'd3);
    chk("mem_req_in_mem", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1 chk_idle("mid_mem_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    f_lat = 99;
    #1;
    chk("rerel_mem_req", 32'(mem_req), 32'd1);
    chk("rerel_mem_fetch", 32'(mem_fetch), 32'd1);
    chk("rerel_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
